serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-multiplexes one external 1-bit full adder (`fa`) to add two WIDTH-bit operands, LSB first. It accepts a start request, drives the adder one bit per clock through operand shift registers and a carry flip-flop, and returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requester (lab top level or a test driver) and a single `fa` instance.

---
 rtl/serial_add_ctrl.sv | 155 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external 1-bit full adder LSB-first
// over WIDTH cycles and returns a WIDTH-bit sum, a carry-out and a done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_i1,
    output logic             fa_i2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [WIDTH-1:0] areg_r;
    logic [WIDTH-1:0] breg_r;
    logic [WIDTH-1:0] sreg_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             last_s;

    // Last serial step: the adder is presenting the MSB of the result
    always_comb begin
        last_s = 1'b0;
        if (state_r == RUN) begin
            last_s = (cnt_r == LAST_CNT);
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state decode; start only matters in IDLE, DONE always returns to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture on accept and one-bit-per-cycle shifting while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg_r  <= {WIDTH{1'b0}};
            breg_r  <= {WIDTH{1'b0}};
            sreg_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        areg_r  <= a;
                        breg_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        areg_r  <= areg_r;
                        breg_r  <= breg_r;
                        carry_r <= carry_r;
                        cnt_r   <= cnt_r;
                    end
                end
                RUN: begin
                    areg_r  <= {1'b0, areg_r[WIDTH-1:1]};
                    breg_r  <= {1'b0, breg_r[WIDTH-1:1]};
                    sreg_r  <= {fa_sum, sreg_r[WIDTH-1:1]};
                    carry_r <= fa_cout;
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                    areg_r  <= areg_r;
                    breg_r  <= breg_r;
                    sreg_r  <= sreg_r;
                    carry_r <= carry_r;
                    cnt_r   <= cnt_r;
                end
            endcase
        end
    end

    // Result registers move only on the final serial step and otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (last_s) begin
            sum_r  <= {fa_sum, sreg_r[WIDTH-1:1]};
            cout_r <= fa_cout;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    // busy_r mirrors the RUN state, so it gates the adder inputs to 0 elsewhere
    assign fa_i1  = busy_r & areg_r[0];
    assign fa_i2  = busy_r & breg_r[0];
    assign fa_cin = busy_r & carry_r;

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder and a
// scoreboard queue of expected {cout,sum} values pushed at each accept.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_i1;
    logic             fa_i2;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks;
    int n_fail;

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_cin;
    logic [WIDTH:0]   prev_res;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .fa_i1   (fa_i1),
        .fa_i2   (fa_i2),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // Behavioural full adder
    assign fa_sum  = fa_i1 ^ fa_i2 ^ fa_cin;
    assign fa_cout = (fa_i1 & fa_i2) | (fa_i1 & fa_cin) | (fa_i2 & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " sum"}, {24'd0, sum}, 32'd0);
        check({tag, " cout"}, {31'd0, cout}, 32'd0);
        check({tag, " fa"}, {29'd0, fa_i1, fa_i2, fa_cin}, 32'd0);
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        logic [WIDTH:0] r;
        cap_a   = av;
        cap_b   = bv;
        cap_cin = cv;
        r = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        exp_q.push_back(r);
    endtask

    // Drive operands with start=1 and return just after the accepting edge
    task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        push_exp(av, bv, cv);
    endtask

    // Walk the WIDTH RUN cycles and the DONE cycle, checking every cycle
    task automatic run_and_check(input string tag, input logic [15:0] smask, input bit toggle);
        logic           c;
        logic [WIDTH:0] expv;
        c = cap_cin;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            @(negedge clk);
            check({tag, " busy"}, {31'd0, busy}, {31'd0, (k <= WIDTH)});
            check({tag, " done"}, {31'd0, done}, {31'd0, (k == WIDTH + 1)});
            if (k <= WIDTH) begin
                check({tag, " fa_i1"}, {31'd0, fa_i1}, {31'd0, cap_a[k-1]});
                check({tag, " fa_i2"}, {31'd0, fa_i2}, {31'd0, cap_b[k-1]});
                check({tag, " fa_cin"}, {31'd0, fa_cin}, {31'd0, c});
                c = (cap_a[k-1] & cap_b[k-1]) | (cap_a[k-1] & c) | (cap_b[k-1] & c);
            end
            if (k == 1) begin
                check({tag, " held"}, {23'd0, cout, sum}, {23'd0, prev_res});
            end
            if (k == WIDTH + 1) begin
                if (exp_q.size() == 0) begin
                    check({tag, " scoreboard empty"}, 32'd1, 32'd0);
                end else begin
                    expv = exp_q.pop_front();
                    check({tag, " result"}, {23'd0, cout, sum}, {23'd0, expv});
                    prev_res = expv;
                end
            end
            start = smask[k];
            if (toggle) begin
                a = ~a;
                b = ~b;
            end
        end
    endtask

    // The cycle after DONE must be IDLE
    task automatic idle_cycle(input string tag, input logic keep_start);
        @(negedge clk);
        check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        check({tag, " idle done"}, {31'd0, done}, 32'd0);
        start = keep_start;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic addition
        accept(8'h5A, 8'h3C, 1'b0);
        run_and_check("basic", 16'h0000, 1'b0);
        idle_cycle("basic", 1'b0);

        // Carry ripple cases
        accept(8'hFF, 8'h01, 1'b0);
        run_and_check("ripple1", 16'h0000, 1'b0);
        idle_cycle("ripple1", 1'b0);
        accept(8'hFF, 8'hFF, 1'b1);
        run_and_check("ripple2", 16'h0000, 1'b0);
        idle_cycle("ripple2", 1'b0);

        // start on RUN cycles 3 and 5 and on the DONE cycle is ignored
        accept(8'h33, 8'h44, 1'b1);
        run_and_check("ignore", 16'h0228, 1'b1);
        idle_cycle("ignore", 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignore quiet busy", {31'd0, busy}, 32'd0);
            check("ignore quiet done", {31'd0, done}, 32'd0);
            check("ignore sum held", {23'd0, cout, sum}, {23'd0, prev_res});
        end

        // Operands toggling during RUN do not disturb the result
        accept(8'h12, 8'h34, 1'b1);
        run_and_check("opchg", 16'h0000, 1'b1);
        idle_cycle("opchg", 1'b0);

        // Asynchronous reset in the middle of RUN cycle 4
        accept(8'hA5, 8'h5A, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun busy before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun reset");
        void'(exp_q.pop_front());
        prev_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        accept(8'h80, 8'h80, 1'b0);
        run_and_check("after reset", 16'h0000, 1'b0);
        idle_cycle("after reset", 1'b0);

        // start held high: one addition every WIDTH+2 cycles
        accept(8'h01, 8'h01, 1'b0);
        for (int n = 0; n < 3; n++) begin
            run_and_check("b2b", 16'hFFFF, 1'b0);
            idle_cycle("b2b", 1'b1);
            @(posedge clk);
            push_exp(8'h01, 8'h01, 1'b0);
        end
        run_and_check("b2b last", 16'h0000, 1'b0);
        idle_cycle("b2b last", 1'b0);

        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
